// File: rtl/rv32_pkg.sv
// Shared RV32 constants and fetch-stage types for the front-end pipeline.
package rv32_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// and loads the IF/ID register with stall hold and redirect bubbles.
module if_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      imem_addr_o,
  output logic             imem_en_o,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc_o,
  output logic             id_valid_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  fetch_state_e r_state, w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_flush;
  logic        r_misalign;

  logic [31:0] w_addr;
  logic        w_load_bubble;
  logic        w_load_fetch;
  logic        w_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // Redirect outranks stall for both the next address and the IF/ID update.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr        = RESET_PC;
    w_load_bubble = 1'b0;
    w_load_fetch  = 1'b0;
    w_hold        = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt   = RUN;
        w_addr        = RESET_PC;
        w_load_bubble = 1'b1;
      end
      RUN: begin
        if (redirect_i) begin
          w_addr        = {redirect_pc_i[31:2], 2'b00};
          w_load_bubble = 1'b1;
        end else if (stall_i) begin
          w_addr = r_pc;
          w_hold = 1'b1;
        end else begin
          w_addr       = r_pc + 32'd4;
          w_load_fetch = 1'b1;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
      r_id_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_pc    <= w_addr;
      r_flush <= (r_state == RUN) && redirect_i;
      if ((r_state == RUN) && redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
      if (w_load_bubble) begin
        r_id_instr <= NOP_INSTR;
        r_id_pc    <= '0;
        r_id_valid <= 1'b0;
      end else if (w_load_fetch) begin
        r_id_instr <= imem_rdata_i;
        r_id_pc    <= r_pc;
        r_id_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_load_fetch),
    .o_count (fetch_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_hold),
    .o_count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_load_bubble),
    .o_count (bubble_cnt_o)
  );

  assign imem_addr_o = w_addr;
  assign imem_en_o   = 1'b1;
  assign id_instr_o  = r_id_instr;
  assign id_pc_o     = r_id_pc;
  assign id_valid_o  = r_id_valid;
  assign flush_o     = r_flush;
  assign misalign_o  = r_misalign;

endmodule
